timer_ctrl: RTL
===============

# timer_ctrl

Countdown sequencer for the Timer display path. Holds an 8-bit seconds value, loads it from switches, and decrements it once per second under start/pause/clear control. Its registered count output drives the binary-to-seven-segment digit decoders directly. Flags completion for the alarm LED.

## Interface

Parameters:
- TICK_DIV, default 50_000_000: clock cycles per count step (1 s at the 50 MHz board clock); benches use 4.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous reset, active-high (fixed)
- load  in  1  level; capture preset into count (IDLE/DONE only)
- preset  in  8  start value in seconds, 0–255
- start  in  1  level; begin or resume counting
- pause  in  1  level; suspend counting
- clear  in  1  level; abort, count to 0, return to IDLE
- count  out  8  current seconds value to digit decoders
- running  out  1  high in RUN
- paused  out  1  high in PAUSED
- done  out  1  high in DONE (count reached 0)
- tick  out  1  one-cycle pulse on every accepted decrement

## Operation

- States: IDLE, RUN, PAUSED, DONE. State is encoded in timer_state_t.
- Reset: state IDLE. count=0, running=0, paused=0, done=0, tick=0, prescaler=0.
- Command priority is checked each cycle: reset > clear > load > start > pause.
- IDLE:
  - load → count<=preset, stay IDLE.
  - start with count≠0 → RUN, prescaler<=0.
  - start with count=0 → DONE.
- RUN:
  - Prescaler increments each cycle. At TICK_DIV-1 it wraps to 0, count<=count-1, and tick=1 for that cycle.
  - If that decrement takes count from 1 to 0, state<=DONE on the same edge.
  - pause (with no start) → PAUSED; the prescaler value is held.
  - clear → IDLE, count<=0, prescaler<=0.
- PAUSED:
  - Count and prescaler frozen.
  - start → RUN, resuming from the held prescaler value (no restart of the partial second).
  - clear → IDLE, count<=0.
  - load ignored.
- DONE:
  - count stays 0, done=1.
  - load → IDLE with count<=preset.
  - clear → IDLE.
  - start and pause ignored.
- Inputs start, pause and clear act on level, not edge. Holding start in DONE does not restart the timer; a new load is required.
- count never underflows: no decrement happens outside RUN, and RUN is never entered with count=0.
- load and start asserted together in IDLE: load wins for that cycle; start is seen next cycle if still high.

## Timing

- All outputs are registered and change one clock after the causing input is sampled.
- start sampled in IDLE at edge N gives running=1 after N.
- The first decrement lands at edge N+TICK_DIV, so count steps are exactly TICK_DIV cycles apart.
- tick is high for exactly the one cycle following each decrement edge, aligned with the new count value.
- done rises in the same cycle count becomes 0. running falls in that cycle too.
- A pause/start pair costs no time: total RUN cycles from start to done equals preset×TICK_DIV regardless of pauses.
- reset asserted mid-count forces all reset values at the next edge; no tick is produced on that edge.

## Structure

- Shared package timer_pkg holds:
  - timer_state_t enum (IDLE, RUN, PAUSED, DONE)
  - COUNT_W=8
  - default TICK_DIV constant, shared with the decoder-side modules
- Sub-module tick_prescaler:
  - Parameterized modulo-TICK_DIV counter with enable, synchronous clear and a wrap pulse output.
  - Instantiated once.
  - Width is $clog2(TICK_DIV).
- The top of timer_ctrl holds the FSM, the count register and the output registers.

## Test plan

All scenarios use TICK_DIV=4.

- Reset then load preset=3, start held: running=1 next cycle; count 3→2→1→0 at 4-cycle spacing; tick pulses 3 times; done=1 and running=0 with count 0; count stays 0 for 20 further cycles.
- preset=5, start, pause after 2 cycles into the second step, hold 10 cycles, start again: count frozen during the pause; remaining step completes after 2 more RUN cycles; total RUN cycles to done = 20.
- load preset=0 then start: DONE on the next cycle, no tick, count=0.
- preset=200, run 3 steps, assert clear: next cycle state IDLE, count=0, no tick. Then start with count=0 → DONE directly.
- load and start asserted together in IDLE with preset=9: count=9 and still IDLE after the first edge; RUN on the following edge.
- reset asserted at the same cycle as a prescaler wrap in RUN: no tick, count=0, all flags 0 on the next cycle.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the timer display path.
// Holds the sequencer state enum, the count width and the default tick divider.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } timer_state_t;

    localparam int COUNT_W = 8;

    // 1 s at the 50 MHz board clock
    localparam int TICK_DIV_DEFAULT = 50_000_000;

endpackage

// File: rtl/tick_prescaler.sv
// Modulo-TICK_DIV counter with enable, synchronous clear and wrap pulse.
// Ports: clk, reset (sync, active-high), en, clr, wrap (combinational, en && last).
module tick_prescaler
    import timer_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        wrap  = en && !clr && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Countdown sequencer: loads seconds from switches, counts down once per tick.
// Ports: clk, reset, load/preset, start, pause, clear in; count, running, paused, done, tick out.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [COUNT_W-1:0] preset,
    input  logic               start,
    input  logic               pause,
    input  logic               clear,
    output logic [COUNT_W-1:0] count,
    output logic               running,
    output logic               paused,
    output logic               done,
    output logic               tick
);

    timer_state_t       state_q;
    timer_state_t       state_d;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
    logic               running_q;
    logic               paused_q;
    logic               done_q;
    logic               tick_q;

    logic presc_en;
    logic presc_clr;
    logic wrap;

    // The edge that samples pause still advances the prescaler, so a
    // pause/resume pair adds no RUN cycles to the total.
    assign presc_en  = (state_q == RUN) && !clear;
    assign presc_clr = clear || (state_q == IDLE);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .clk   (clk),
        .reset (reset),
        .en    (presc_en),
        .clr   (presc_clr),
        .wrap  (wrap)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (clear) begin
                    count_d = '0;
                end else if (load) begin
                    count_d = preset;
                end else if (start) begin
                    state_d = (count_q == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (clear) begin
                    state_d = IDLE;
                    count_d = '0;
                end else begin
                    if (wrap) begin
                        count_d = count_q - COUNT_W'(1);
                    end
                    if (wrap && count_q == COUNT_W'(1)) begin
                        state_d = DONE;
                    end else if (pause && !start) begin
                        state_d = PAUSED;
                    end
                end
            end
            PAUSED: begin
                if (clear) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (start) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (clear) begin
                    state_d = IDLE;
                end else if (load) begin
                    state_d = IDLE;
                    count_d = preset;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
            done_q    <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            running_q <= (state_d == RUN);
            paused_q  <= (state_d == PAUSED);
            done_q    <= (state_d == DONE);
            tick_q    <= wrap;
        end
    end

    assign count   = count_q;
    assign running = running_q;
    assign paused  = paused_q;
    assign done    = done_q;
    assign tick    = tick_q;

endmodule
